// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined W x W multiplier between
// two requesters; a tag pipeline routes each product back to its owner.
module mul_share_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req1_valid,
    output logic           req1_ready,
    output logic           sel,
    output logic           mul_issue,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp0_valid,
    output logic [2*W-1:0] rsp0_p,
    output logic           rsp1_valid,
    output logic [2*W-1:0] rsp1_p,
    output logic           busy
);

    logic           ptr_q, ptr_d;
    logic           gnt_id;
    logic           issue;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [2*W-1:0] rsp0_p_q, rsp0_p_d;
    logic [2*W-1:0] rsp1_p_q, rsp1_p_d;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~ptr_q : req1_valid;
        issue      = ~rst & ~hold & (req0_valid | req1_valid);
        req0_ready = issue & ~gnt_id;
        req1_ready = issue & gnt_id;
        mul_issue  = issue;
        // Idle keeps the mux parked on the last grant so the datapath sees no toggle.
        sel        = rst ? 1'b0 : (issue ? gnt_id : ptr_q);
        ptr_d      = issue ? gnt_id : ptr_q;
    end

    always_comb begin
        tag_vld_d[0] = issue;
        tag_id_d[0]  = sel;
    end

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_tag
            always_comb begin
                tag_vld_d[gi] = tag_vld_q[gi-1];
                tag_id_d[gi]  = tag_id_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        rsp0_valid_d = tag_vld_q[LAT-1] & ~tag_id_q[LAT-1];
        rsp1_valid_d = tag_vld_q[LAT-1] & tag_id_q[LAT-1];
        rsp0_p_d     = rsp0_valid_d ? mul_p : rsp0_p_q;
        rsp1_p_d     = rsp1_valid_d ? mul_p : rsp1_p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b1;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_p_q     <= '0;
            rsp1_p_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_p_q     <= rsp0_p_d;
            rsp1_p_q     <= rsp1_p_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_p     = rsp0_p_q;
    assign rsp1_p     = rsp1_p_q;
    assign busy       = (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: stands in for the shared multiplier and checks
// grants and responses against a cycle-indexed scoreboard of expected events.
module tb_mul_share_arbiter;
    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int NC  = 4096;

    logic           clk = 1'b0;
    logic           rst, hold, req0_valid, req1_valid;
    logic           req0_ready, req1_ready, sel, mul_issue;
    logic [2*W-1:0] mul_p;
    logic           rsp0_valid, rsp1_valid, busy;
    logic [2*W-1:0] rsp0_p, rsp1_p;
    logic [W-1:0]   a0, b0, a1, b1;

    always #5 clk = ~clk;

    mul_share_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .sel(sel), .mul_issue(mul_issue), .mul_p(mul_p),
        .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .busy(busy)
    );

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Multiplier stand-in: operands picked through the mux by sel, LAT-cycle pipe.
    logic [2*W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_issue ? (sel ? prod(a1, b1) : prod(a0, b0)) : '0;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[LAT-1];

    // Scoreboard: what the response ports must show in each cycle.
    bit             due_v  [NC];
    bit             due_id [NC];
    logic [2*W-1:0] due_p  [NC];
    int             cyc;
    bit             last;
    logic [2*W-1:0] exp_p0, exp_p1;
    int             total, passes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit r, input bit h, input bit v0, input bit v1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1);
        bit iss, g, eb;
        rst = r; hold = h; req0_valid = v0; req1_valid = v1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        #2;
        iss = !r && !h && (v0 || v1);
        g   = (v0 && v1) ? !last : v1;
        if (due_v[cyc]) begin
            if (due_id[cyc]) exp_p1 = due_p[cyc];
            else exp_p0 = due_p[cyc];
        end
        eb = 1'b0;
        for (int k = 0; k <= LAT; k++) eb |= due_v[cyc+k];
        chk("req0_ready", 32'(req0_ready), 32'(iss && !g));
        chk("req1_ready", 32'(req1_ready), 32'(iss && g));
        chk("mul_issue",  32'(mul_issue),  32'(iss));
        chk("sel",        32'(sel),        32'(r ? 1'b0 : (iss ? g : last)));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(due_v[cyc] && !due_id[cyc]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(due_v[cyc] && due_id[cyc]));
        chk("rsp0_p",     32'(rsp0_p),     32'(exp_p0));
        chk("rsp1_p",     32'(rsp1_p),     32'(exp_p1));
        chk("busy",       32'(busy),       32'(eb));
        @(posedge clk);
        if (r) begin
            last = 1'b1;
            exp_p0 = '0; exp_p1 = '0;
            for (int k = 1; k <= LAT + 1; k++) due_v[cyc+k] = 1'b0;
        end else if (iss) begin
            due_v[cyc+LAT+1]  = 1'b1;
            due_id[cyc+LAT+1] = g;
            due_p[cyc+LAT+1]  = g ? prod(x1, y1) : prod(x0, y0);
            last = g;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [W-1:0] rop();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        total = 0; passes = 0; cyc = 0; last = 1'b1;
        exp_p0 = '0; exp_p1 = '0;
        for (int i = 0; i < NC; i++) begin due_v[i] = 0; due_id[i] = 0; due_p[i] = '0; end
        rst = 1; hold = 0; req0_valid = 0; req1_valid = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Single request from requester 0, then drain.
        step(0, 0, 1, 0, 3, 5, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Fresh reset, then both valid continuously: strict alternation.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, W'(10+i), W'(20+i), W'(30+i), W'(40+i));
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Requester 1 alone after reset, then a tie.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, W'(7+i), 9);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, W'(2+i), 11, W'(4+i), 13);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Hold after two issues: in-flight drain, busy falls after last response.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 100, 2, 50, 3);
        step(0, 0, 1, 1, 101, 2, 51, 3);
        repeat (6) step(0, 1, 1, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 6, 7, 8, 9);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset one cycle after an issue discards it.
        step(0, 0, 1, 0, 200, 200, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 12, 12, 13, 13);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Operand corners through both ports, interleaved.
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, (i & 1) ? 8'hFF : 8'h00, (i & 2) ? 8'hFF : 8'h00,
                 (i & 2) ? 8'hFF : 8'h00, (i & 1) ? 8'hFF : 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 0, 0, 1, 0, 0, 8'hFF, 8'hFF);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional hold and reset.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom), 1'($urandom), rop(), rop(), rop(), rop());
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
